mux2_4_arb: RTL and testbench

Two-requester round-robin arbiter that shares one `mux2_4` 4-bit 2:1 datapath between sources A and B. Each source presents data with a valid/ready handshake. The arbiter drives the mux select, captures the mux output into a one-entry output register, and presents it downstream with valid/ready plus a source tag. The grant can be held for a configurable burst of consecutive transfers, then rotates.

---
 rtl/mux2_4_arb.sv | 110 +++++++++++
 tb/tb_mux2_4_arb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux2_4_arb.sv
// Round-robin two-source arbiter feeding one 4-bit 2:1 mux into a one-entry
// output register, with a configurable per-source burst length.
module mux2_4_arb #(
  parameter int unsigned BURST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [3:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [3:0] b_data,
  output logic       b_ready,
  output logic       sel,
  output logic       q_valid,
  output logic [3:0] q_data,
  output logic       q_src,
  input  logic       q_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic [3:0] BURST_CNT = 4'(BURST);

  state_t     state, state_next;
  logic [3:0] cnt;
  logic       last;

  logic       load;
  logic       has_win;
  logic       win_a;
  logic       cont;
  logic       owner_a;
  logic       owner_valid;
  logic       other_valid;
  logic [3:0] mux_y;

  assign load        = !q_valid || q_ready;
  assign owner_a     = (state == GNT_A);
  assign owner_valid = owner_a ? a_valid : b_valid;
  assign other_valid = owner_a ? b_valid : a_valid;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    has_win = 1'b0;
    win_a   = 1'b0;
    cont    = 1'b0;
    if (state == IDLE) begin
      has_win = a_valid || b_valid;
      // On a tie the source that did not go last wins; last = B favours A.
      if (a_valid && b_valid) win_a = !last;
      else                    win_a = a_valid;
    end else if (owner_valid && (cnt < BURST_CNT)) begin
      has_win = 1'b1;
      win_a   = owner_a;
      cont    = 1'b1;
    end else if (other_valid) begin
      has_win = 1'b1;
      win_a   = !owner_a;
    end else if (owner_valid) begin
      has_win = 1'b1;
      win_a   = owner_a;
    end
  end

  assign sel     = has_win && win_a;
  assign mux_y   = sel ? a_data : b_data;
  assign a_ready = !rst && load && has_win && win_a;
  assign b_ready = !rst && load && has_win && !win_a;

  always_comb begin
    state_next = state;
    if (load) begin
      if (!has_win)   state_next = IDLE;
      else if (win_a) state_next = GNT_A;
      else            state_next = GNT_B;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      last    <= 1'b0;
      q_valid <= 1'b0;
      q_data  <= 4'd0;
      q_src   <= 1'b0;
    end else if (load) begin
      state <= state_next;
      if (has_win) begin
        q_valid <= 1'b1;
        q_data  <= mux_y;
        q_src   <= win_a;
        last    <= win_a;
        cnt     <= cont ? cnt + 4'd1 : 4'd1;
      end else begin
        cnt     <= 4'd0;
        q_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_4_arb.sv
// Directed bench for mux2_4_arb: three instances (BURST = 1, 2, 3) share the
// same stimulus; each scenario checks the instance it is aimed at.
module tb_mux2_4_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, q_ready;
  logic [3:0] a_data, b_data;

  logic [2:0] a_ready_w, b_ready_w, sel_w, q_valid_w, q_src_w;
  logic [3:0] q_data_w [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux2_4_arb #(.BURST(g + 1)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .a_valid (a_valid),
      .a_data  (a_data),
      .a_ready (a_ready_w[g]),
      .b_valid (b_valid),
      .b_data  (b_data),
      .b_ready (b_ready_w[g]),
      .sel     (sel_w[g]),
      .q_valid (q_valid_w[g]),
      .q_data  (q_data_w[g]),
      .q_src   (q_src_w[g]),
      .q_ready (q_ready)
    );
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; q_ready = 1'b1;
    a_data = 4'd0; b_data = 4'd0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  logic [3:0] a_seq [4] = '{4'b1111, 4'b1110, 4'b1101, 4'b1100};
  logic       src1  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       src2  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       src3  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    // Reset with both sources requesting and downstream ready.
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; q_ready = 1'b1;
    a_data = 4'b1010; b_data = 4'b0101;
    cycle();
    cycle();
    settle();
    check("rst_q_valid", {3'b0, q_valid_w[0]}, 4'b0000);
    check("rst_q_data",  q_data_w[0], 4'b0000);
    check("rst_q_src",   {3'b0, q_src_w[0]}, 4'b0000);
    check("rst_readies", {2'b0, a_ready_w[0], b_ready_w[0]}, 4'b0000);
    rst = 1'b0;
    settle();
    check("rel_sel_a",   {3'b0, sel_w[0]}, 4'b0001);
    check("rel_readies", {2'b0, a_ready_w[0], b_ready_w[0]}, 4'b0010);
    cycle();
    check("rel_q_data", q_data_w[0], 4'b1010);
    check("rel_q_src",  {3'b0, q_src_w[0]}, 4'b0001);

    // A only, BURST = 1: back-to-back transfers, one cycle latency.
    do_reset();
    a_valid = 1'b1; b_valid = 1'b0; q_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_data = a_seq[i];
      settle();
      check("aonly_a_ready", {3'b0, a_ready_w[0]}, 4'b0001);
      cycle();
      check("aonly_q_valid", {3'b0, q_valid_w[0]}, 4'b0001);
      check("aonly_q_data",  q_data_w[0], a_seq[i]);
      check("aonly_q_src",   {3'b0, q_src_w[0]}, 4'b0001);
    end

    // Contention: both valid continuously, per-BURST grant patterns.
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 4'b1111; b_data = 4'b0000;
    q_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("cont_b1_src",  {3'b0, q_src_w[0]}, {3'b0, src1[i]});
      check("cont_b1_data", q_data_w[0], src1[i] ? 4'b1111 : 4'b0000);
      check("cont_b2_src",  {3'b0, q_src_w[1]}, {3'b0, src2[i]});
      check("cont_b3_src",  {3'b0, q_src_w[2]}, {3'b0, src3[i]});
    end
    // BURST = 2: B gets one transfer, then drops; A is re-granted at once.
    cycle();
    check("drop_b2_src_b", {3'b0, q_src_w[1]}, 4'b0000);
    b_valid = 1'b0;
    settle();
    check("drop_b2_readies", {2'b0, a_ready_w[1], b_ready_w[1]}, 4'b0010);
    check("drop_b2_sel",     {3'b0, sel_w[1]}, 4'b0001);
    cycle();
    check("drop_b2_src_a",  {3'b0, q_src_w[1]}, 4'b0001);
    check("drop_b2_q_data", q_data_w[1], 4'b1111);

    // Backpressure on BURST = 1: output frozen, readies low, sel still live.
    do_reset();
    a_valid = 1'b1; a_data = 4'b1101; b_valid = 1'b0; q_ready = 1'b1;
    cycle();
    check("bp_first_data", q_data_w[0], 4'b1101);
    q_ready = 1'b0; a_data = 4'b1100; b_valid = 1'b1; b_data = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("bp_hold_data",  q_data_w[0], 4'b1101);
      check("bp_hold_valid", {3'b0, q_valid_w[0]}, 4'b0001);
      check("bp_readies",    {2'b0, a_ready_w[0], b_ready_w[0]}, 4'b0000);
      check("bp_sel_b",      {3'b0, sel_w[0]}, 4'b0000);
      cycle();
    end
    q_ready = 1'b1;
    settle();
    check("bp_release_readies", {2'b0, a_ready_w[0], b_ready_w[0]}, 4'b0001);
    cycle();
    check("bp_next_data",  q_data_w[0], 4'b0011);
    check("bp_next_src",   {3'b0, q_src_w[0]}, 4'b0000);
    check("bp_next_valid", {3'b0, q_valid_w[0]}, 4'b0001);

    // Reset in the middle of a BURST = 3 run of A transfers.
    do_reset();
    a_valid = 1'b1; a_data = 4'b0001; b_valid = 1'b0; q_ready = 1'b1;
    cycle();
    cycle();
    check("mid_pre_src", {3'b0, q_src_w[2]}, 4'b0001);
    rst = 1'b1; b_valid = 1'b1; b_data = 4'b0110; a_data = 4'b1001;
    cycle();
    check("mid_rst_q_valid", {3'b0, q_valid_w[2]}, 4'b0000);
    check("mid_rst_q_data",  q_data_w[2], 4'b0000);
    rst = 1'b0;
    settle();
    check("mid_sel_a", {3'b0, sel_w[2]}, 4'b0001);
    cycle();
    check("mid_q_src",  {3'b0, q_src_w[2]}, 4'b0001);
    check("mid_q_data", q_data_w[2], 4'b1001);

    // Drain with no source: output empties, state returns to idle.
    a_valid = 1'b0; b_valid = 1'b0;
    settle();
    check("drain_readies", {2'b0, a_ready_w[2], b_ready_w[2]}, 4'b0000);
    cycle();
    check("drain_q_valid", {3'b0, q_valid_w[2]}, 4'b0000);
    // After going idle with last = A, a tie now goes to B.
    a_valid = 1'b1; b_valid = 1'b1;
    settle();
    check("idle_tie_sel_b", {3'b0, sel_w[2]}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
